mmio_region_router: RTL and testbench

MMIO_REGION_ROUTER -- requirements
Module: mmio_region_router

---
 rtl/mmio_region_router.sv | 197 +++++++++++++++++++
 tb/tb_mmio_region_router.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_region_router.sv
// MMIO request router: decodes a byte address into one of NREG regions, forwards the request,
// and returns responses strictly in acceptance order through an in-order tracking FIFO.
module mmio_region_router #(
    parameter int NREG   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE  = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NREG*ADDR_W-1:0] REGION_LIMIT = {32'h8001_ffff, 32'h7fff_ffff}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_op,
    input  logic [1:0]             req_size,
    input  logic [DATA_W/8-1:0]    req_we,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [1:0]             rsp_op,
    output logic [1:0]             rsp_size,
    output logic [NREG-1:0]        s_req_valid,
    input  logic [NREG-1:0]        s_req_ready,
    output logic [ADDR_W-1:0]      s_addr,
    output logic [DATA_W/8-1:0]    s_we,
    output logic [DATA_W-1:0]      s_wdata,
    input  logic [NREG-1:0]        s_rsp_valid,
    output logic [NREG-1:0]        s_rsp_ready,
    input  logic [NREG*DATA_W-1:0] s_rsp_rdata
);
    localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic [SEL_W-1:0]  sel_s;
    logic              hit_any_s;
    logic              miss_s;
    logic              is_op_s;
    logic              not_full_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] base_sel_s;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    logic [SEL_W-1:0]  ent_sel_q  [DEPTH];
    logic              ent_miss_q [DEPTH];
    logic [1:0]        ent_op_q   [DEPTH];
    logic [1:0]        ent_size_q [DEPTH];

    logic [SEL_W-1:0]  head_sel_s;
    logic              head_miss_s;
    logic [1:0]        head_op_s;
    logic [1:0]        head_size_s;
    logic [DATA_W-1:0] head_rdata_s;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        rsp_op_q, rsp_op_d;
    logic [1:0]        rsp_size_q, rsp_size_d;

    function automatic logic in_region(input int idx, input logic [ADDR_W-1:0] addr);
        return (addr >= REGION_BASE[idx*ADDR_W +: ADDR_W]) &&
               (addr <= REGION_LIMIT[idx*ADDR_W +: ADDR_W]);
    endfunction

    // Address decode: descending scan so the lowest matching region index wins
    always_comb begin
        hit_any_s = 1'b0;
        sel_s     = {SEL_W{1'b0}};
        for (int i = NREG - 1; i >= 0; i--) begin
            hit_any_s = hit_any_s | in_region(i, req_addr);
            sel_s     = in_region(i, req_addr) ? SEL_W'(i) : sel_s;
        end
    end

    // Request handshake and shared slave request bus
    always_comb begin
        miss_s      = !hit_any_s || (req_op == OP_RSVD);
        is_op_s     = (req_op != OP_NONE);
        not_full_s  = (count_q < CNT_W'(DEPTH));
        base_sel_s  = REGION_BASE[sel_s*ADDR_W +: ADDR_W];
        s_addr      = req_addr - base_sel_s;
        s_we        = (req_op == OP_STORE) ? req_we : {BE_W{1'b0}};
        s_wdata     = req_wdata;
        s_req_valid = {NREG{1'b0}};
        if (is_op_s) begin
            req_ready = not_full_s && (miss_s || s_req_ready[sel_s]);
        end else begin
            req_ready = 1'b1;
        end
        if (req_valid && is_op_s && !miss_s && not_full_s && !reset) begin
            s_req_valid[sel_s] = 1'b1;
        end else begin
            s_req_valid = {NREG{1'b0}};
        end
        push_s = req_valid && req_ready && is_op_s;
    end

    assign head_sel_s  = ent_sel_q[rd_ptr_q];
    assign head_miss_s = ent_miss_q[rd_ptr_q];
    assign head_op_s   = ent_op_q[rd_ptr_q];
    assign head_size_s = ent_size_q[rd_ptr_q];

    // Head retirement: misses retire at once, hits wait for their own region's response
    always_comb begin
        s_rsp_ready  = {NREG{1'b0}};
        pop_s        = 1'b0;
        head_rdata_s = s_rsp_rdata[head_sel_s*DATA_W +: DATA_W];
        if ((count_q != {CNT_W{1'b0}}) && !reset) begin
            if (head_miss_s) begin
                pop_s = 1'b1;
            end else if (s_rsp_valid[head_sel_s]) begin
                s_rsp_ready[head_sel_s] = 1'b1;
                pop_s                   = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy, pointer and response-register next state
    always_comb begin
        wr_ptr_d    = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        rsp_valid_d = pop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (pop_s) begin
            rsp_rdata_d = head_miss_s ? {DATA_W{1'b0}} : head_rdata_s;
            rsp_err_d   = head_miss_s;
            rsp_op_d    = head_op_s;
            rsp_size_d  = head_size_s;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
            rsp_op_d    = rsp_op_q;
            rsp_size_d  = rsp_size_q;
        end
    end

    // Control and response registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            rsp_op_q    <= 2'b00;
            rsp_size_q  <= 2'b00;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_op_q    <= rsp_op_d;
            rsp_size_q  <= rsp_size_d;
        end
    end

    // Tracking entry payload; only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_s) begin
            ent_sel_q[wr_ptr_q]  <= sel_s;
            ent_miss_q[wr_ptr_q] <= miss_s;
            ent_op_q[wr_ptr_q]   <= req_op;
            ent_size_q[wr_ptr_q] <= req_size;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_size  = rsp_size_q;

endmodule

// File: tb/tb_mmio_region_router.sv
// Self-checking bench for mmio_region_router: decode vector table, directed ordering/full/reset
// sequences, then random traffic against a queue-based transaction model.
module tb_mmio_region_router;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_op;
    logic [1:0]  rsp_size;
    logic [1:0]  s_req_valid;
    logic [1:0]  s_req_ready;
    logic [31:0] s_addr;
    logic [3:0]  s_we;
    logic [31:0] s_wdata;
    logic [1:0]  s_rsp_valid;
    logic [1:0]  s_rsp_ready;
    logic [63:0] s_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_region_router dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_size(req_size), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_op(rsp_op), .rsp_size(rsp_size),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_we(s_we), .s_wdata(s_wdata),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [3:0]  we;
        logic [1:0]  srdy;
        logic [1:0]  exp_sv;
        logic        exp_rdy;
        logic [3:0]  exp_we;
        logic        chk_addr;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        miss;
        int          rgn;
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] data;
    } ent_t;

    vec_t        vecs [10];
    ent_t        outq [$];
    ent_t        e;
    logic [31:0] base_a  [2];
    logic [31:0] limit_a [2];
    logic [31:0] front_d [2];
    logic [31:0] bnd     [6];
    logic [1:0]  present;
    logic        m_miss, m_pop, e_rdy;
    logic [1:0]  e_sv, e_srr;
    int          hit_r, idx, cnt;
    logic        x_valid, x_err;
    logic [31:0] x_rdata;
    logic [1:0]  x_op, x_size;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 32'h0;
        req_we    = 4'h0;
        req_size  = 2'b00;
        req_wdata = 32'h0;
    endtask

    task automatic load_req(input logic [31:0] a, input logic [1:0] op, input logic [3:0] we);
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        req_we    = we;
        req_size  = 2'b10;
        req_wdata = $urandom;
    endtask

    initial begin
        reset       = 1'b1;
        idle();
        s_req_ready = 2'b11;
        s_rsp_valid = 2'b11;
        s_rsp_rdata = 64'h1111_2222_3333_4444;
        req_valid   = 1'b1;
        req_op      = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_rsp_op", rsp_op, 2'b00);
        chk("reset_rsp_size", rsp_size, 2'b00);
        chk("reset_s_req_valid", s_req_valid, 2'b00);
        chk("reset_s_rsp_ready", s_rsp_ready, 2'b00);

        // Load to region 0 accepted on the very first edge after release
        s_rsp_valid = 2'b00;
        reset       = 1'b0;
        s_req_ready = 2'b01;
        load_req(32'h0000_0010, 2'b01, 4'h0);
        #1;
        chk("a_ready", req_ready, 1'b1);
        chk("a_sv", s_req_valid, 2'b01);
        chk("a_saddr", s_addr, 32'h10);
        tick();
        idle();
        #1;
        chk("a_no_pop", s_rsp_ready, 2'b00);
        tick();
        s_rsp_valid = 2'b01;
        s_rsp_rdata = {32'h0, 32'hDEAD_BEEF};
        #1;
        chk("a_pop", s_rsp_ready, 2'b01);
        chk("a_rsp_pending", rsp_valid, 1'b0);
        tick();
        s_rsp_valid = 2'b00;
        #1;
        chk("a_rsp_valid", rsp_valid, 1'b1);
        chk("a_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("a_rsp_err", rsp_err, 1'b0);
        chk("a_rsp_op", rsp_op, 2'b01);
        chk("a_rsp_size", rsp_size, 2'b10);
        tick();
        chk("a_one_cycle", rsp_valid, 1'b0);
        chk("a_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Decode table: inputs applied and removed before the edge so nothing is pushed
        vecs[0] = '{32'h0000_0010, 2'b01, 4'hf, 2'b01, 2'b01, 1'b1, 4'h0, 1'b1, 32'h0000_0010};
        vecs[1] = '{32'h8000_0004, 2'b10, 4'hf, 2'b10, 2'b10, 1'b1, 4'hf, 1'b1, 32'h0000_0004};
        vecs[2] = '{32'h9000_0000, 2'b01, 4'hf, 2'b00, 2'b00, 1'b1, 4'h0, 1'b0, 32'h0};
        vecs[3] = '{32'h7fff_ffff, 2'b01, 4'h0, 2'b00, 2'b01, 1'b0, 4'h0, 1'b1, 32'h7fff_ffff};
        vecs[4] = '{32'h8001_ffff, 2'b10, 4'h3, 2'b10, 2'b10, 1'b1, 4'h3, 1'b1, 32'h0001_ffff};
        vecs[5] = '{32'h8002_0000, 2'b10, 4'hf, 2'b11, 2'b00, 1'b1, 4'hf, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_0010, 2'b11, 4'hf, 2'b11, 2'b00, 1'b1, 4'h0, 1'b0, 32'h0};
        vecs[7] = '{32'h0000_0010, 2'b00, 4'hf, 2'b11, 2'b00, 1'b1, 4'h0, 1'b0, 32'h0};
        vecs[8] = '{32'h8000_0000, 2'b01, 4'hf, 2'b01, 2'b10, 1'b0, 4'h0, 1'b1, 32'h0};
        vecs[9] = '{32'h0000_0000, 2'b10, 4'h5, 2'b00, 2'b01, 1'b0, 4'h5, 1'b1, 32'h0};
        for (int v = 0; v < 10; v++) begin
            load_req(vecs[v].addr, vecs[v].op, vecs[v].we);
            s_req_ready = vecs[v].srdy;
            #1;
            chk($sformatf("vec%0d_sv", v), s_req_valid, vecs[v].exp_sv);
            chk($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_rdy);
            chk($sformatf("vec%0d_swe", v), s_we, vecs[v].exp_we);
            chk($sformatf("vec%0d_swdata", v), s_wdata, req_wdata);
            if (vecs[v].chk_addr) begin
                chk($sformatf("vec%0d_saddr", v), s_addr, vecs[v].exp_addr);
            end
            idle();
            tick();
        end

        // Store to region 1 returns through the load path with its op tag
        s_req_ready = 2'b10;
        load_req(32'h8000_0004, 2'b10, 4'hf);
        #1;
        chk("b_sv", s_req_valid, 2'b10);
        chk("b_saddr", s_addr, 32'h4);
        chk("b_swe", s_we, 4'hf);
        tick();
        idle();
        tick();
        s_rsp_valid = 2'b10;
        s_rsp_rdata = {32'h1234_5678, 32'h0};
        #1;
        chk("b_pop", s_rsp_ready, 2'b10);
        tick();
        s_rsp_valid = 2'b00;
        chk("b_rsp_valid", rsp_valid, 1'b1);
        chk("b_rsp_op", rsp_op, 2'b10);
        chk("b_rsp_rdata", rsp_rdata, 32'h1234_5678);

        // Unmapped load retires as an error one cycle after reaching the head
        s_req_ready = 2'b00;
        load_req(32'h9000_0000, 2'b01, 4'h0);
        #1;
        chk("c_sv", s_req_valid, 2'b00);
        chk("c_ready", req_ready, 1'b1);
        tick();
        idle();
        chk("c_not_yet", rsp_valid, 1'b0);
        tick();
        chk("c_rsp_valid", rsp_valid, 1'b1);
        chk("c_rsp_err", rsp_err, 1'b1);
        chk("c_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk("c_one_cycle", rsp_valid, 1'b0);

        // Region 0 answers first but must wait behind the older region 1 load
        s_req_ready = 2'b11;
        load_req(32'h8000_0100, 2'b01, 4'h0);
        #1;
        chk("d_sv1", s_req_valid, 2'b10);
        tick();
        load_req(32'h0000_0020, 2'b01, 4'h0);
        #1;
        chk("d_sv0", s_req_valid, 2'b01);
        tick();
        idle();
        s_rsp_valid = 2'b01;
        s_rsp_rdata = {32'h0, 32'hAAAA_0001};
        #1;
        chk("d_hold0_a", s_rsp_ready, 2'b00);
        tick();
        chk("d_hold0_b", s_rsp_ready, 2'b00);
        chk("d_no_rsp", rsp_valid, 1'b0);
        tick();
        s_rsp_valid = 2'b11;
        s_rsp_rdata = {32'hBBBB_0002, 32'hAAAA_0001};
        #1;
        chk("d_pop1", s_rsp_ready, 2'b10);
        tick();
        s_rsp_valid = 2'b01;
        #1;
        chk("d_rsp1_valid", rsp_valid, 1'b1);
        chk("d_rsp1_rdata", rsp_rdata, 32'hBBBB_0002);
        chk("d_pop0", s_rsp_ready, 2'b01);
        tick();
        s_rsp_valid = 2'b00;
        chk("d_rsp0_valid", rsp_valid, 1'b1);
        chk("d_rsp0_rdata", rsp_rdata, 32'hAAAA_0001);
        tick();
        chk("d_done", rsp_valid, 1'b0);

        // Fill the tracker, then a single response frees the fifth request a cycle later
        s_req_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            load_req(32'h0000_0100 + 32'(4 * k), 2'b01, 4'h0);
            #1;
            chk($sformatf("e_fill%0d", k), req_ready, 1'b1);
            tick();
        end
        load_req(32'h0000_0200, 2'b01, 4'h0);
        #1;
        chk("e_full_ready", req_ready, 1'b0);
        chk("e_full_sv", s_req_valid, 2'b00);
        tick();
        s_rsp_valid = 2'b01;
        s_rsp_rdata = {32'h0, 32'hC0C0_0001};
        #1;
        chk("e_pop", s_rsp_ready, 2'b01);
        chk("e_still_full", req_ready, 1'b0);
        tick();
        s_rsp_valid = 2'b00;
        #1;
        chk("e_ready_after", req_ready, 1'b1);
        chk("e_sv_after", s_req_valid, 2'b01);
        chk("e_rsp", rsp_valid, 1'b1);
        tick();
        idle();
        s_rsp_valid = 2'b01;
        s_rsp_rdata = {32'h0, 32'hD0D0_0002};
        tick();
        s_rsp_valid = 2'b00;
        chk("e_drain_rsp", rsp_valid, 1'b1);

        // Reset with three entries outstanding
        reset = 1'b1;
        s_rsp_valid = 2'b01;
        load_req(32'h0000_0300, 2'b01, 4'h0);
        #1;
        chk("f_rsp_valid", rsp_valid, 1'b0);
        chk("f_rsp_rdata", rsp_rdata, 32'h0);
        chk("f_rsp_op", rsp_op, 2'b00);
        chk("f_srr", s_rsp_ready, 2'b00);
        chk("f_sv", s_req_valid, 2'b00);
        tick();
        tick();
        reset = 1'b0;
        idle();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("f_stale_rsp%0d", k), rsp_valid, 1'b0);
            chk($sformatf("f_stale_srr%0d", k), s_rsp_ready, 2'b00);
            tick();
        end
        s_rsp_valid = 2'b00;

        // Random traffic against a transaction-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_a[0]  = 32'h0000_0000;
        base_a[1]  = 32'h8000_0000;
        limit_a[0] = 32'h7fff_ffff;
        limit_a[1] = 32'h8001_ffff;
        bnd[0] = 32'h7fff_ffff; bnd[1] = 32'h8000_0000; bnd[2] = 32'h8001_ffff;
        bnd[3] = 32'h8002_0000; bnd[4] = 32'hffff_ffff; bnd[5] = 32'h0000_0000;
        present = 2'b00;
        x_valid = 1'b0; x_err = 1'b0; x_rdata = 32'h0; x_op = 2'b00; x_size = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                idx = -1;
                for (int k = 0; k < outq.size(); k++) begin
                    if (idx < 0 && !outq[k].miss && outq[k].rgn == r) idx = k;
                end
                if (idx < 0) begin
                    present[r] = 1'b0;
                    front_d[r] = $urandom;
                end else begin
                    if (!present[r] && $urandom_range(0, 2) == 0) present[r] = 1'b1;
                    front_d[r] = outq[idx].data;
                end
            end
            s_rsp_valid = present;
            s_rsp_rdata = {front_d[1], front_d[0]};
            req_valid   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       req_op = 2'b00;
                1:       req_op = 2'b11;
                2, 3, 4: req_op = 2'b10;
                default: req_op = 2'b01;
            endcase
            case ($urandom_range(0, 3))
                0:       req_addr = $urandom & 32'h7fff_ffff;
                1:       req_addr = 32'h8000_0000 + 32'($urandom_range(0, 32'h1ffff));
                2:       req_addr = bnd[$urandom_range(0, 5)];
                default: req_addr = $urandom;
            endcase
            req_size    = 2'($urandom);
            req_we      = 4'($urandom);
            req_wdata   = $urandom;
            s_req_ready = 2'($urandom);

            hit_r = -1;
            for (int r = 0; r < 2; r++) begin
                if (hit_r < 0 && req_addr >= base_a[r] && req_addr <= limit_a[r]) hit_r = r;
            end
            m_miss = (hit_r < 0) || (req_op == 2'b11);
            cnt    = outq.size();
            if (req_op == 2'b00) e_rdy = 1'b1;
            else if (cnt >= DEPTH) e_rdy = 1'b0;
            else if (m_miss) e_rdy = 1'b1;
            else e_rdy = s_req_ready[hit_r];
            e_sv = 2'b00;
            if (req_valid && req_op != 2'b00 && !m_miss && cnt < DEPTH) e_sv[hit_r] = 1'b1;
            m_pop = (cnt > 0) && (outq[0].miss || present[outq[0].rgn]);
            e_srr = 2'b00;
            if (m_pop && !outq[0].miss) e_srr[outq[0].rgn] = 1'b1;

            #1;
            chk("r_ready", req_ready, e_rdy);
            chk("r_sv", s_req_valid, e_sv);
            chk("r_srr", s_rsp_ready, e_srr);
            chk("r_rsp_valid", rsp_valid, x_valid);
            chk("r_rsp_rdata", rsp_rdata, x_rdata);
            chk("r_rsp_err", rsp_err, x_err);
            chk("r_rsp_op", rsp_op, x_op);
            chk("r_rsp_size", rsp_size, x_size);
            if (e_sv != 2'b00) begin
                chk("r_saddr", s_addr, req_addr - base_a[hit_r]);
                chk("r_swe", s_we, (req_op == 2'b10) ? req_we : 4'h0);
            end

            if (m_pop) begin
                x_valid = 1'b1;
                x_err   = outq[0].miss;
                x_rdata = outq[0].miss ? 32'h0 : outq[0].data;
                x_op    = outq[0].op;
                x_size  = outq[0].size;
                if (!outq[0].miss) present[outq[0].rgn] = 1'b0;
                void'(outq.pop_front());
            end else begin
                x_valid = 1'b0;
            end
            if (req_valid && e_rdy && req_op != 2'b00) begin
                e.miss = m_miss;
                e.rgn  = m_miss ? 0 : hit_r;
                e.op   = req_op;
                e.size = req_size;
                e.data = $urandom;
                outq.push_back(e);
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
